// File: rtl/thread_sched_4t.sv
// thread_sched_4t: four-thread round-robin fetch scheduler.
// Each thread owns a PC and may have at most one fetch in flight.
// Issue outputs depend only on registered state. There is no path from
// any input to an output in the same cycle.
// Optional build macro GPC_SCHED_PERF_CNT_EN adds the per-thread
// saturating issue counters on port IssueCntQnnnH.
module thread_sched_4t #(
  parameter logic [31:0] RST_PC_BASE   = 32'h0000_0000,
  parameter logic [31:0] RST_PC_STRIDE = 32'h0000_0400
) (
  input  logic        QClk,
  input  logic        RstQnnnH,
  input  logic [3:0]  ThreadEnQnnnH,
  input  logic [3:0]  RstPcQnnnH,
  input  logic        FbValidQ101H,
  input  logic [1:0]  FbTidQ101H,
  input  logic [31:0] FbNextPcQ101H,
  output logic        IssueValidQ100H,
  output logic [1:0]  TidQ100H,
  output logic [31:0] PcQ100H,
  output logic        SchedErrQnnnH
`ifdef GPC_SCHED_PERF_CNT_EN
  ,
  output logic [3:0][15:0] IssueCntQnnnH
`endif
);

  logic [3:0][31:0] pc_q, pc_d;
  logic [3:0]       in_flight_q, in_flight_d;
  logic [3:0]       drop_q, drop_d;
  logic [3:0]       en_q;
  logic [1:0]       last_tid_q;
  logic             err_q, err_d;

  logic [3:0]       eligible;
  logic             grant_valid;
  logic [1:0]       grant_tid;
  logic [1:0]       cand;

  function automatic logic [31:0] rst_pc(input int n);
    return RST_PC_BASE + RST_PC_STRIDE * 32'(n);
  endfunction

  assign eligible = en_q & ~in_flight_q;

  // Round-robin pick: scan from the farthest offset down, so the nearest
  // eligible thread after last_tid is the one that remains selected.
  always_comb begin
    grant_valid = 1'b0;
    grant_tid   = last_tid_q;
    cand        = last_tid_q;
    for (int k = 4; k >= 1; k--) begin
      cand = last_tid_q + 2'(k);
      if (eligible[cand]) begin
        grant_valid = 1'b1;
        grant_tid   = cand;
      end
    end
  end

  assign IssueValidQ100H = grant_valid;
  assign TidQ100H        = grant_tid;
  assign PcQ100H         = pc_q[grant_tid];
  assign SchedErrQnnnH   = err_q;

  // Next-state: feedback first, then issue, then PC-reset requests. A PC
  // reset on a thread that is still in flight at the end of the cycle sets
  // drop. This includes a thread that issues in the same cycle. The
  // returning feedback then belongs to the abandoned PC stream.
  always_comb begin
    pc_d        = pc_q;
    in_flight_d = in_flight_q;
    drop_d      = drop_q;
    err_d       = err_q;
    if (FbValidQ101H) begin
      if (in_flight_q[FbTidQ101H]) begin
        in_flight_d[FbTidQ101H] = 1'b0;
        if (drop_q[FbTidQ101H]) drop_d[FbTidQ101H] = 1'b0;
        else                    pc_d[FbTidQ101H]   = FbNextPcQ101H;
      end else begin
        err_d = 1'b1;
      end
    end
    if (grant_valid) in_flight_d[grant_tid] = 1'b1;
    for (int n = 0; n < 4; n++) begin
      if (RstPcQnnnH[n]) begin
        pc_d[n] = rst_pc(n);
        if (in_flight_d[n]) drop_d[n] = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge QClk) begin
    if (!RstQnnnH) begin
      for (int n = 0; n < 4; n++) pc_q[n] <= rst_pc(n);
      in_flight_q <= '0;
      drop_q      <= '0;
      en_q        <= '0;
      last_tid_q  <= 2'd3;
      err_q       <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      in_flight_q <= in_flight_d;
      drop_q      <= drop_d;
      en_q        <= ThreadEnQnnnH;
      if (grant_valid) last_tid_q <= grant_tid;
      err_q       <= err_d;
    end
  end

`ifdef GPC_SCHED_PERF_CNT_EN
  logic [3:0][15:0] issue_cnt_q;

  // Per-thread issue counters that saturate at all-ones.
  always_ff @(posedge QClk) begin
    if (!RstQnnnH) begin
      issue_cnt_q <= '0;
    end else if (grant_valid && (issue_cnt_q[grant_tid] != 16'hFFFF)) begin
      issue_cnt_q[grant_tid] <= issue_cnt_q[grant_tid] + 16'd1;
    end
  end

  assign IssueCntQnnnH = issue_cnt_q;
`endif

endmodule
